// File: rtl/mult_div_unit_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e    : operation encodings presented on op
//   - md_state_e : sequencing FSM states
//   - WIDTH_DEF  : default operand / HI / LO width
package md_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Handshake / data bundle between the issue logic and the multiply/divide unit.
//   start, op, busA, busB   : operation request and operands
//   mt_we, mt_sel, busW     : MTHI / MTLO direct writes
//   hi, lo, busy, done      : architectural HI/LO and status
// master = requester side, slave = mult_div_unit side.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             mt_we;
    logic             mt_sel;
    logic [WIDTH-1:0] busW;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, busA, busB, mt_we, mt_sel, busW,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, busA, busB, mt_we, mt_sel, busW,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit_iter_step.sv
// md_iter_step: one iteration of the magnitude datapath (pure combinational).
//   acc_i    : partial accumulator
//              multiply: {partial product high, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd_i   : multiplicand (multiply) or divisor (divide) magnitude
//   is_div_i : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_o    : accumulator after this iteration
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shl;
    logic [WIDTH:0]   trial;

    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        shl   = {acc_i, 1'b0};
        // Partial remainder is always < 2*divisor, so a non-negative trial
        // fits in WIDTH bits and bit WIDTH acts as the borrow flag.
        trial = shl[2*WIDTH:WIDTH] - {1'b0, opnd_i};
        acc_o = acc_i;
        if (is_div_i) begin
            if (!trial[WIDTH]) begin
                acc_o = {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = shl[2*WIDTH-1:0];
            end
        end else if (acc_i[0]) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine holding HI/LO.
//   clk  : clock, rising edge
//   rstb : synchronous reset, active-high
//   bus  : mult_div_unit_if.slave (start/op/busA/busB, MT writes, hi/lo/busy/done)
// Signed operations run on magnitudes; signs are re-applied in FIX.
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO writes accepted
//   RUN   | one datapath iteration per cycle, counter counting down
//   FIX   | sign correction, HI/LO written, done pulsed next cycle
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rstb,
    mult_div_unit_if.slave  bus
);

    localparam int ITER = WIDTH;
    localparam int CW   = $clog2(ITER + 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               sgn_quo_q, sgn_quo_d;
    logic               sgn_rem_q, sgn_rem_d;
    logic               div0_q, div0_d;
    logic               done_q, done_d;

    logic               op_signed, op_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        div0_d    = div0_q;
        done_d    = 1'b0;

        op_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
        op_div    = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
        a_mag     = (op_signed && bus.busA[WIDTH-1]) ? -bus.busA : bus.busA;
        b_mag     = (op_signed && bus.busB[WIDTH-1]) ? -bus.busB : bus.busB;

        prod_fix  = sgn_quo_q ? -acc_q : acc_q;
        // Divide by zero leaves an all-ones quotient magnitude; force it so
        // the dividend sign cannot flip it. The remainder path already
        // reconstructs the latched dividend.
        quo_fix   = div0_q ? {WIDTH{1'b1}}
                           : (sgn_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix   = sgn_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (bus.mt_we) begin
                    if (bus.mt_sel) hi_d = bus.busW;
                    else            lo_d = bus.busW;
                end
                if (bus.start) begin
                    is_div_d  = op_div;
                    sgn_quo_d = op_signed && (bus.busA[WIDTH-1] ^ bus.busB[WIDTH-1]);
                    sgn_rem_d = op_signed && bus.busA[WIDTH-1];
                    div0_d    = op_div && (bus.busB == '0);
                    opnd_d    = op_div ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                    cnt_d     = CW'(ITER);
                    state_d   = RUN;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit directly downstream of register_file.
- Consumes busA (rs) and busB (rt) for MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers.
- HI/LO feed the writeback mux for MFHI/MFLO, which returns them to register_file via busW. MTHI/MTLO write HI/LO directly.
- Uses an iterative shift-add multiplier and a restoring divider, one bit per cycle.

Parameters:
WIDTH, 32, operand and HI/LO width
ITER, WIDTH, iteration cycles per operation (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rstb  input  1  synchronous reset, active-high (rstb=1 resets at next rising edge)
start  input  1  request an operation; sampled only when busy=0
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU (md_pkg encodings)
busA  input  WIDTH  rs operand (multiplicand / dividend)
busB  input  WIDTH  rt operand (multiplier / divisor)
mt_we  input  1  MTHI/MTLO write enable
mt_sel  input  1  0=write LO, 1=write HI
busW  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in progress
done  output  1  one-cycle pulse: hi/lo just updated by a completed operation

Behaviour:
- Reset (rstb=1 at an edge):
  - hi=0, lo=0, busy=0, done=0; FSM to IDLE; iteration counter=0.
  - Reset has priority over start, mt_we and any in-flight operation. A mid-operation result is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0: latch op, busA and busB.
  - Signed ops latch absolute values plus the result signs: sign_q = a31^b31; sign_r = a31.
  - Counter loads ITER; busy=1 after E0; go to RUN.
- RUN: one iteration per edge (E1..E32); counter decrements; when it reaches 0, go to FIX.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring divide producing quotient and remainder magnitudes.
- FIX (edge E33):
  - Apply sign correction. Multiply: negate the 64-bit product if sign_q. Divide: negate the quotient if sign_q; negate the remainder if sign_r.
  - Write hi/lo. Multiply: {hi,lo}=product. Divide: lo=quotient, hi=remainder.
  - busy=0, done=1 for exactly one cycle; back to IDLE.
- Latency: hi/lo/done valid on the output in the cycle after edge E33, i.e. 33 edges after the start edge. Throughput: one operation per 34 cycles; a new start is accepted the cycle done is high.
- start while busy=1: ignored; the operation in flight is unaffected.
- mt_we:
  - busy=0: the selected register gets busW at the next edge.
  - busy=1: ignored.
  - Same edge as an accepted start: the MT write happens and the operation still launches.
- Divide by zero: no exception. lo=32'hFFFFFFFF; hi=busA as latched (signed and unsigned). Normal latency, done pulses.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are never re-read from busA/busB after E0; upstream may change them freely.
- hi/lo are held stable between writes. They are readable at all times, including while busy, when they show the old value.

Decomposition:
- md_pkg: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), FSM state typedef (IDLE, RUN, FIX), WIDTH default.
- One sub-module, md_iter_step: combinational single-iteration datapath. Input is the partial accumulator plus op class; output is the next accumulator. mult_div_unit holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULTU busA=0xFFFFFFFF, busB=0xFFFFFFFF -> after 33 edges done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT busA=0xFFFFFFFD (-3), busB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV busA=0xFFFFFFF9 (-7), busB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU busA=100, busB=7 -> lo=14, hi=2. DIVU busA=0x1234, busB=0 -> lo=0xFFFFFFFF, hi=0x1234.
- Start MULTU 6*7; at cycle 10 assert start with DIVU 9/3 and mt_we=1 (mt_sel=1, busW=0xAA) -> both ignored; final hi=0, lo=42; one done pulse only.
- MTHI busW=0x55 and MTLO busW=0x66 while idle -> hi=0x55, lo=0x66 next cycle. Then start DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT, assert rstb=1 at cycle 15 -> next cycle busy=0, done=0, hi=lo=0; no done pulse afterward. A new start is then accepted normally.
